// File: rtl/mips_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mips_ctrl_pkg
// Shared definitions for the multicycle MIPS control unit:
//   - statetype : 4-bit base state encoding (zero-extended to STATE_W at the top)
//   - opcode / funct field values decoded by the controller
//   - 3-bit ALU control codes driven onto alucontrol
//   - aluop_t   : how the ALU decoder should pick the ALU operation
// Optional feature macro used by the design: MIPS_CTRL_JAL_EN.
// -----------------------------------------------------------------------------
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPE   = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    IMMEX   = 4'd9,
    IMMWB   = 4'd10,
    JUMP    = 4'd11,
    ILLEGAL = 4'd12,
    JAL     = 4'd13
  } statetype;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  // R-type funct codes (IR[5:0])
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_XOR = 6'b100110;
  localparam logic [5:0] F_NOR = 6'b100111;
  localparam logic [5:0] F_SLT = 6'b101010;

  // ALU control codes
  localparam logic [2:0] ALUC_AND = 3'b000;
  localparam logic [2:0] ALUC_OR  = 3'b001;
  localparam logic [2:0] ALUC_ADD = 3'b010;
  localparam logic [2:0] ALUC_XOR = 3'b011;
  localparam logic [2:0] ALUC_NOR = 3'b100;
  localparam logic [2:0] ALUC_SUB = 3'b110;
  localparam logic [2:0] ALUC_SLT = 3'b111;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'd0,
    ALU_SUB   = 2'd1,
    ALU_FUNCT = 2'd2,
    ALU_IMM   = 2'd3
  } aluop_t;

endpackage

// File: rtl/mips_alu_dec.sv
// -----------------------------------------------------------------------------
// mips_alu_dec
// Combinational ALU decoder for the multicycle MIPS controller.
// Ports:
//   aluop      in  aluop_t  operation class requested by the FSM
//   funct      in  6        IR[5:0], used when aluop = ALU_FUNCT
//   opcode     in  6        IR[31:26], used when aluop = ALU_IMM
//   alucontrol out 3        ALU control code
//   imm_zext   out 1        zero-extend the immediate (andi/ori)
//   funct_ok   out 1        funct is one of the supported R-type operations
// -----------------------------------------------------------------------------
module mips_alu_dec
  import mips_ctrl_pkg::*;
(
  input  aluop_t      aluop,
  input  logic [5:0]  funct,
  input  logic [5:0]  opcode,
  output logic [2:0]  alucontrol,
  output logic        imm_zext,
  output logic        funct_ok
);

  logic [2:0] funct_code;
  logic [2:0] imm_code;
  logic       imm_is_logical;

  // Funct decode is computed unconditionally so the FSM can reject an
  // unsupported R-type instruction while it is in RTYPE.
  // NOTE: every output of a combinational block gets a default before the
  // case statement; a path that leaves one unassigned would infer a latch.
  always_comb begin
    funct_code = ALUC_ADD;
    funct_ok   = 1'b1;
    case (funct)
      F_ADD:   funct_code = ALUC_ADD;
      F_SUB:   funct_code = ALUC_SUB;
      F_AND:   funct_code = ALUC_AND;
      F_OR:    funct_code = ALUC_OR;
      F_XOR:   funct_code = ALUC_XOR;
      F_NOR:   funct_code = ALUC_NOR;
      F_SLT:   funct_code = ALUC_SLT;
      default: funct_ok   = 1'b0;
    endcase
  end

  always_comb begin
    imm_code       = ALUC_ADD;
    imm_is_logical = 1'b0;
    case (opcode)
      OP_ADDI: imm_code = ALUC_ADD;
      OP_ANDI: begin
        imm_code       = ALUC_AND;
        imm_is_logical = 1'b1;
      end
      OP_ORI: begin
        imm_code       = ALUC_OR;
        imm_is_logical = 1'b1;
      end
      OP_SLTI: imm_code = ALUC_SLT;
      default: imm_code = ALUC_ADD;
    endcase
  end

  always_comb begin
    alucontrol = ALUC_ADD;
    imm_zext   = 1'b0;
    case (aluop)
      ALU_ADD:   alucontrol = ALUC_ADD;
      ALU_SUB:   alucontrol = ALUC_SUB;
      ALU_FUNCT: alucontrol = funct_code;
      ALU_IMM: begin
        alucontrol = imm_code;
        imm_zext   = imm_is_logical;
      end
      default:   alucontrol = ALUC_ADD;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// mips_multicycle_ctrl
// Moore-style control FSM for a shared-memory multicycle MIPS datapath with a
// variable-latency memory handshake (mem_ready), immediate ALU ops, beq/bne,
// j, and an illegal-instruction trap with a saturating counter.
// Optional feature: define MIPS_CTRL_JAL_EN to add the JAL state (13).
// Parameters: STATE_W (>=4), ALUCTL_W (>=3), ILL_CNT_W.
// Ports:
//   clk, reset (async, active-high)
//   opcode, funct       instruction fields from IR
//   zero                ALU zero flag (branch qualification)
//   mem_ready           memory completes the current access this cycle
//   state_o             current state, zero-extended to STATE_W
//   iord, alusrca, alusrcb, alucontrol, imm_zext, regdst, memtoreg, pcsrc
//                       datapath mux selects / ALU control
//   irwrite, memwrite, regwrite, pcen
//                       datapath enables, forced low while reset is high
//   illegal, ill_count  trap pulse and saturating trap counter
// -----------------------------------------------------------------------------
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int STATE_W   = 5,
  parameter int ALUCTL_W  = 3,
  parameter int ILL_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [5:0]           opcode,
  input  logic [5:0]           funct,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic [STATE_W-1:0]   state_o,
  output logic                 iord,
  output logic                 alusrca,
  output logic [1:0]           alusrcb,
  output logic [ALUCTL_W-1:0]  alucontrol,
  output logic                 imm_zext,
  output logic                 irwrite,
  output logic                 memwrite,
  output logic                 regwrite,
  output logic [1:0]           regdst,
  output logic [1:0]           memtoreg,
  output logic [1:0]           pcsrc,
  output logic                 pcen,
  output logic                 illegal,
  output logic [ILL_CNT_W-1:0] ill_count
);

  statetype   state, next_state;
  aluop_t     aluop;
  logic [2:0] alu_code;
  logic       funct_ok;
  logic       pcwrite, branch, is_bne;
  logic       irwrite_s, memwrite_s, regwrite_s, illegal_s;

  mips_alu_dec u_alu_dec (
    .aluop      (aluop),
    .funct      (funct),
    .opcode     (opcode),
    .alucontrol (alu_code),
    .imm_zext   (imm_zext),
    .funct_ok   (funct_ok)
  );

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the pre-edge value of its inputs regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FETCH;
    else       state <= next_state;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ill_count <= '0;
    end else if (state == ILLEGAL && ill_count != '1) begin
      ill_count <= ill_count + ILL_CNT_W'(1);
    end
  end

  always_comb begin
    next_state = FETCH;
    iord       = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'd0;
    aluop      = ALU_ADD;
    regdst     = 2'd0;
    memtoreg   = 2'd0;
    pcsrc      = 2'd0;
    irwrite_s  = 1'b0;
    memwrite_s = 1'b0;
    regwrite_s = 1'b0;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    illegal_s  = 1'b0;

    case (state)
      FETCH: begin
        alusrcb    = 2'd1;
        irwrite_s  = mem_ready;
        pcwrite    = mem_ready;
        next_state = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        alusrcb = 2'd3;
        case (opcode)
          OP_RTYPE:                          next_state = RTYPE;
          OP_LW, OP_SW:                      next_state = MEMADR;
          OP_BEQ, OP_BNE:                    next_state = BRANCH;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: next_state = IMMEX;
          OP_J:                              next_state = JUMP;
`ifdef MIPS_CTRL_JAL_EN
          OP_JAL:                            next_state = JAL;
`else
          OP_JAL:                            next_state = ILLEGAL;
`endif
          default:                           next_state = ILLEGAL;
        endcase
      end
      MEMADR: begin
        alusrca    = 1'b1;
        alusrcb    = 2'd2;
        next_state = (opcode == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        iord       = 1'b1;
        next_state = mem_ready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        memtoreg   = 2'd1;
        regwrite_s = 1'b1;
        next_state = FETCH;
      end
      MEMWR: begin
        // The write strobe stays up for the whole access; memory latches it
        // on the cycle it raises mem_ready.
        iord       = 1'b1;
        memwrite_s = 1'b1;
        next_state = mem_ready ? FETCH : MEMWR;
      end
      RTYPE: begin
        alusrca    = 1'b1;
        aluop      = ALU_FUNCT;
        next_state = funct_ok ? ALUWB : ILLEGAL;
      end
      ALUWB: begin
        regdst     = 2'd1;
        regwrite_s = 1'b1;
        next_state = FETCH;
      end
      BRANCH: begin
        alusrca    = 1'b1;
        aluop      = ALU_SUB;
        pcsrc      = 2'd1;
        branch     = 1'b1;
        next_state = FETCH;
      end
      IMMEX: begin
        alusrca    = 1'b1;
        alusrcb    = 2'd2;
        aluop      = ALU_IMM;
        next_state = IMMWB;
      end
      IMMWB: begin
        regwrite_s = 1'b1;
        next_state = FETCH;
      end
      JUMP: begin
        pcsrc      = 2'd2;
        pcwrite    = 1'b1;
        next_state = FETCH;
      end
      ILLEGAL: begin
        illegal_s  = 1'b1;
        next_state = FETCH;
      end
`ifdef MIPS_CTRL_JAL_EN
      JAL: begin
        regdst     = 2'd2;
        memtoreg   = 2'd2;
        regwrite_s = 1'b1;
        pcsrc      = 2'd2;
        pcwrite    = 1'b1;
        next_state = FETCH;
      end
`endif
      default: next_state = FETCH;
    endcase
  end

  // bne takes the branch when the operands differ, i.e. when zero is low.
  assign is_bne = (opcode == OP_BNE);

  // Reset forces the state to FETCH asynchronously, but FETCH enables follow
  // mem_ready combinationally, so the enables are also masked by reset itself.
  assign irwrite  = irwrite_s  & ~reset;
  assign memwrite = memwrite_s & ~reset;
  assign regwrite = regwrite_s & ~reset;
  assign illegal  = illegal_s  & ~reset;
  assign pcen     = (pcwrite | (branch & (zero ^ is_bne))) & ~reset;

  assign state_o    = STATE_W'(state);
  assign alucontrol = ALUCTL_W'(alu_code);

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mips_multicycle_ctrl
// Scoreboard bench: each stimulus cycle pushes the hand-computed expected
// outputs for that cycle (-1 = don't care); a monitor pops and compares on
// the falling edge. Define MIPS_CTRL_JAL_EN for both bench and RTL to test JAL.
// -----------------------------------------------------------------------------
module tb_mips_multicycle_ctrl;
  import mips_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode, funct;
  logic       zero, mem_ready;
  logic [4:0] state_o;
  logic       iord, alusrca, imm_zext, irwrite, memwrite, regwrite, pcen, illegal;
  logic [1:0] alusrcb, regdst, memtoreg, pcsrc;
  logic [2:0] alucontrol;
  logic [7:0] ill_count;

  mips_multicycle_ctrl #(.STATE_W(5), .ALUCTL_W(3), .ILL_CNT_W(8)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .state_o(state_o), .iord(iord), .alusrca(alusrca),
    .alusrcb(alusrcb), .alucontrol(alucontrol), .imm_zext(imm_zext),
    .irwrite(irwrite), .memwrite(memwrite), .regwrite(regwrite),
    .regdst(regdst), .memtoreg(memtoreg), .pcsrc(pcsrc), .pcen(pcen),
    .illegal(illegal), .ill_count(ill_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    int st, pcen, irw, rw, mw, ill, cnt;
    int aluc, zext, regdst, m2r, pcsrc, srcb, iord;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   exp_ill = 0;

  logic [5:0] cur_op = 6'd0, cur_fn = 6'd0;

  function automatic exp_t ex(string n, int st, int pc = -1, int irw = -1,
                              int rw = -1, int mw = -1, int ill = -1);
    exp_t e;
    e.name = n; e.st = st; e.pcen = pc; e.irw = irw; e.rw = rw; e.mw = mw;
    e.ill = ill; e.cnt = -1; e.aluc = -1; e.zext = -1; e.regdst = -1;
    e.m2r = -1; e.pcsrc = -1; e.srcb = -1; e.iord = -1;
    return e;
  endfunction

  task automatic chk(string n, string f, int act, int expv);
    if (expv >= 0) begin
      n_tests++;
      if (act != expv) begin
        n_fail++;
        $display("FAIL %s.%s: got %0d expected %0d", n, f, act, expv);
      end
    end
  endtask

  // Monitor: compares the DUT against the oldest pending expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk(e.name, "state",      int'(state_o),    e.st);
        chk(e.name, "pcen",       int'(pcen),       e.pcen);
        chk(e.name, "irwrite",    int'(irwrite),    e.irw);
        chk(e.name, "regwrite",   int'(regwrite),   e.rw);
        chk(e.name, "memwrite",   int'(memwrite),   e.mw);
        chk(e.name, "illegal",    int'(illegal),    e.ill);
        chk(e.name, "ill_count",  int'(ill_count),  e.cnt);
        chk(e.name, "alucontrol", int'(alucontrol), e.aluc);
        chk(e.name, "imm_zext",   int'(imm_zext),   e.zext);
        chk(e.name, "regdst",     int'(regdst),     e.regdst);
        chk(e.name, "memtoreg",   int'(memtoreg),   e.m2r);
        chk(e.name, "pcsrc",      int'(pcsrc),      e.pcsrc);
        chk(e.name, "alusrcb",    int'(alusrcb),    e.srcb);
        chk(e.name, "iord",       int'(iord),       e.iord);
      end
    end
  end

  // One clock cycle of stimulus: drive inputs just after the edge and queue
  // what the outputs must be during this cycle.
  task automatic step(input logic mr, input logic z, input exp_t e);
    @(posedge clk);
    #1;
    opcode    = cur_op;
    funct     = cur_fn;
    mem_ready = mr;
    zero      = z;
    sb.push_back(e);
  endtask

  // FETCH completing immediately, then DECODE.
  task automatic fetch_decode(input logic [5:0] op, input logic [5:0] fn, input string n);
    exp_t e;
    cur_op = op;
    cur_fn = fn;
    e = ex({n, "_fetch"}, 0, 1, 1, 0, 0, 0);
    e.srcb = 1; e.aluc = 2; e.iord = 0; e.pcsrc = 0;
    step(1'b1, 1'b0, e);
    e = ex({n, "_decode"}, 1, 0, 0, 0, 0, 0);
    e.srcb = 3; e.aluc = 2;
    step(1'b0, 1'b0, e);
  endtask

  task automatic illegal_cycle(input string n);
    exp_t e;
    e = ex(n, 12, 0, 0, 0, 0, 1);
    e.cnt = exp_ill;
    step(1'b0, 1'b0, e);
    if (exp_ill < 255) exp_ill++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    reset = 1'b1; opcode = 6'd0; funct = 6'd0; zero = 1'b0; mem_ready = 1'b1;

    // Reset with mem_ready high: enables must stay low, FETCH selects shown.
    e = ex("reset", 0, 0, 0, 0, 0, 0);
    e.cnt = 0; e.srcb = 1; e.aluc = 2; e.iord = 0; e.pcsrc = 0;
    step(1'b1, 1'b0, e);
    @(negedge clk);
    #1 reset = 1'b0; mem_ready = 1'b0;

    // lw with 3 wait cycles in FETCH and 2 in MEMRD.
    cur_op = OP_LW;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, ex("lw_fwait", 0, 0, 0, 0, 0));
    e = ex("lw_fetch", 0, 1, 1, 0, 0); step(1'b1, 1'b0, e);
    e = ex("lw_decode", 1, 0, 0, 0, 0); step(1'b0, 1'b0, e);
    e = ex("lw_memadr", 2, 0, 0, 0, 0); e.srcb = 2; e.aluc = 2; step(1'b0, 1'b0, e);
    e = ex("lw_memrd0", 3, 0, 0, 0, 0); e.iord = 1; step(1'b0, 1'b0, e);
    e = ex("lw_memrd1", 3, 0, 0, 0, 0); e.iord = 1; step(1'b0, 1'b0, e);
    e = ex("lw_memrd2", 3, 0, 0, 0, 0); e.iord = 1; step(1'b1, 1'b0, e);
    e = ex("lw_memwb", 4, 0, 0, 1, 0); e.regdst = 0; e.m2r = 1; step(1'b0, 1'b0, e);
    e = ex("lw_done", 0, 0, 0, 0, 0); step(1'b0, 1'b0, e);

    // Branches.
    fetch_decode(OP_BEQ, 6'd0, "beq_z1");
    e = ex("beq_z1_br", 8, 1, 0, 0, 0); e.pcsrc = 1; e.aluc = 6; step(1'b0, 1'b1, e);
    fetch_decode(OP_BNE, 6'd0, "bne_z1");
    e = ex("bne_z1_br", 8, 0, 0, 0, 0); e.pcsrc = 1; step(1'b0, 1'b1, e);
    fetch_decode(OP_BNE, 6'd0, "bne_z0");
    e = ex("bne_z0_br", 8, 1, 0, 0, 0); e.pcsrc = 1; step(1'b0, 1'b0, e);
    fetch_decode(OP_BEQ, 6'd0, "beq_z0");
    e = ex("beq_z0_br", 8, 0, 0, 0, 0); step(1'b0, 1'b0, e);

    // Immediate ops.
    fetch_decode(OP_ORI, 6'd0, "ori");
    e = ex("ori_immex", 9, 0, 0, 0, 0); e.aluc = 1; e.zext = 1; e.srcb = 2; step(1'b0, 1'b0, e);
    e = ex("ori_immwb", 10, 0, 0, 1, 0); e.regdst = 0; e.m2r = 0; step(1'b0, 1'b0, e);
    fetch_decode(OP_ANDI, 6'd0, "andi");
    e = ex("andi_immex", 9); e.aluc = 0; e.zext = 1; step(1'b0, 1'b0, e);
    e = ex("andi_immwb", 10, 0, 0, 1); step(1'b0, 1'b0, e);
    fetch_decode(OP_SLTI, 6'd0, "slti");
    e = ex("slti_immex", 9); e.aluc = 7; e.zext = 0; step(1'b0, 1'b0, e);
    e = ex("slti_immwb", 10, 0, 0, 1); step(1'b0, 1'b0, e);

    // R-type: nor, then an unsupported funct.
    fetch_decode(OP_RTYPE, 6'b100111, "nor");
    e = ex("nor_rtype", 6, 0, 0, 0, 0); e.aluc = 4; e.srcb = 0; step(1'b0, 1'b0, e);
    e = ex("nor_aluwb", 7, 0, 0, 1, 0, 0); e.regdst = 1; e.m2r = 0; step(1'b0, 1'b0, e);
    fetch_decode(OP_RTYPE, 6'b101010, "slt");
    e = ex("slt_rtype", 6); e.aluc = 7; step(1'b0, 1'b0, e);
    e = ex("slt_aluwb", 7, 0, 0, 1); step(1'b0, 1'b0, e);
    fetch_decode(OP_RTYPE, 6'b111111, "badfn");
    e = ex("badfn_rtype", 6, 0, 0, 0, 0, 0); step(1'b0, 1'b0, e);
    illegal_cycle("badfn_illegal");
    e = ex("badfn_after", 0, 0, 0, 0, 0, 0); e.cnt = 1; step(1'b0, 1'b0, e);

    // Jump.
    fetch_decode(OP_J, 6'd0, "j");
    e = ex("j_jump", 11, 1, 0, 0, 0); e.pcsrc = 2; step(1'b0, 1'b0, e);

    // jal: its own state when enabled, otherwise trapped.
    fetch_decode(OP_JAL, 6'd0, "jal");
`ifdef MIPS_CTRL_JAL_EN
    e = ex("jal_state", 13, 1, 0, 1, 0, 0); e.regdst = 2; e.m2r = 2; e.pcsrc = 2;
    step(1'b0, 1'b0, e);
`else
    illegal_cycle("jal_illegal");
`endif

    // sw completing after one wait cycle.
    fetch_decode(OP_SW, 6'd0, "sw");
    e = ex("sw_memadr", 2); e.srcb = 2; step(1'b0, 1'b0, e);
    e = ex("sw_memwr0", 5, 0, 0, 0, 1); e.iord = 1; step(1'b0, 1'b0, e);
    e = ex("sw_memwr1", 5, 0, 0, 0, 1); e.iord = 1; step(1'b1, 1'b0, e);
    e = ex("sw_done", 0, 0, 0, 0, 0); step(1'b0, 1'b0, e);

    // 256 illegal opcodes: counter saturates at 255.
    for (int i = 0; i < 256; i++) begin
      fetch_decode(6'b111111, 6'd0, "illop");
      illegal_cycle("illop_trap");
    end
    e = ex("sat_after", 0); e.cnt = 255; step(1'b0, 1'b0, e);

    // Reset asserted mid-write: strobe drops without a clock edge.
    fetch_decode(OP_SW, 6'd0, "swrst");
    e = ex("swrst_memadr", 2); step(1'b0, 1'b0, e);
    e = ex("swrst_memwr", 5, 0, 0, 0, 1); step(1'b0, 1'b0, e);
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    e = ex("swrst_inreset", 0, 0, 0, 0, 0, 0); e.cnt = 0;
    sb.push_back(e);
    @(negedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, ex("swrst_release", 0, 0, 0, 0, 0));

    repeat (3) @(negedge clk);
    chk("drain", "pending", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
